dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Two-requester arbiter and access sequencer in front of the single data-memory port.
//  Requester 0 is the core load/store unit; requester 1 is the debug/DMA loader.
//  Performs RISC-V sub-word handling: store lane placement and byte enables,
//  and load extract with sign/zero extension.
//  Sequences each access as grant -> issue -> (wait) -> response.
// PARAMETERS
//  DM_ADDRESS  9   byte-address width of data memory
//  DATA_W      32  data word width (fixed 32; 4 byte lanes)
// PORTS
//  clk         in   1           single clock, rising edge
//  rst_n       in   1           asynchronous, active-low reset
//  mN_req      in   1           N=0,1: request; held with fields stable until mN_gnt
//  mN_we       in   1           1=store, 0=load
//  mN_addr     in   DM_ADDRESS  byte address
//  mN_wdata    in   DATA_W      store data, right-aligned (SB uses [7:0], SH uses [15:0])
//  mN_funct3   in   3           000 b, 001 h, 010 w, 100 bu, 101 hu
//  mN_gnt      out  1           one-cycle pulse: request accepted
//  mN_rvalid   out  1           one-cycle pulse: access complete (loads and stores)
//  mN_rdata    out  DATA_W      load result, valid with mN_rvalid, else 0
//  mN_err      out  1           misaligned or illegal funct3, valid with mN_rvalid
//  mem_addr    out  DM_ADDRESS  word address to memory ({addr[DM_ADDRESS-1:2],2'b00})
//  mem_re      out  1           read strobe; mem_rdata is valid the following cycle
//  mem_we      out  1           write strobe
//  mem_be      out  4           byte enables, bit i = lane [8i+7:8i]
//  mem_wdata   out  DATA_W      lane-placed store data
//  mem_rdata   in   DATA_W      memory read data, 1-cycle latency
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; every output 0; rr pointer favours m0.
//   Reset mid-access aborts the access; no rvalid for it.
//  FSM: IDLE -> ISSUE -> WAIT (loads only) -> RESP -> IDLE.
//  Grant is given only in IDLE; mN_gnt is combinational from req in IDLE.
//   The request is captured at that edge (cycle T).
//  Arbitration: one requester -> it wins. Both -> the one not granted last (round robin).
//   The rr pointer updates on every grant.
//  ISSUE (T+1):
//   - Store: mem_we=1, mem_be/mem_wdata lane-placed by addr[1:0].
//     SW: be=1111. SH: be=0011<<addr[1:0]. SB: be=0001<<addr[1:0]; data replicated per lane.
//   - Load: mem_re=1.
//   - mem_* outputs are 0 in every other state.
//  WAIT (T+2, loads): capture mem_rdata.
//   Extract the byte/half at addr[1:0]; sign-extend for 000/001, zero-extend for 100/101.
//  RESP: rvalid pulses to the granted master. Loads at T+3; stores at T+2 with rdata=0.
//  Error: half at odd address, word with addr[1:0]!=0, or funct3 011/11x (load) / not 0xx (store).
//   ISSUE drives no mem strobe; RESP carries err=1, rdata=0; state goes straight to RESP.
//  Throughput: load 4 cycles, store 3 cycles; next grant is possible in the IDLE cycle after RESP.
//  A requester dropping req before gnt is legal; no grant is issued to it.
//  The non-granted requester's outputs stay 0 throughout.
// TESTING
//  1. m0 SW addr=0x10 wdata=0xDEADBEEF -> gnt T, T+1 mem_we=1 be=1111 addr=0x10, rvalid T+2.
//  2. m0 LB addr=0x13, mem word 0x80FF_0000 -> T+1 mem_re; T+3 rvalid, rdata=0xFFFF_FF80.
//     Repeat with LBU -> rdata=0x0000_0080.
//  3. m1 SH addr=0x06 wdata=0x0000_1234 -> mem_be=1100, mem_wdata[31:16]=0x1234.
//  4. m0 and m1 request together continuously -> grants alternate m0,m1,m0,m1; after reset m0 first.
//  5. m0 LW addr=0x05 -> no mem_re/mem_we; rvalid T+2 with err=1, rdata=0.
//  6. rst_n low during WAIT -> all outputs 0 immediately; no rvalid; next request is granted normally.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port seen by dmem_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface dmem_port_arbiter_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  m0_req;
  logic                  m0_we;
  logic [DM_ADDRESS-1:0] m0_addr;
  logic [DATA_W-1:0]     m0_wdata;
  logic [2:0]            m0_funct3;
  logic                  m0_gnt;
  logic                  m0_rvalid;
  logic [DATA_W-1:0]     m0_rdata;
  logic                  m0_err;

  logic                  m1_req;
  logic                  m1_we;
  logic [DM_ADDRESS-1:0] m1_addr;
  logic [DATA_W-1:0]     m1_wdata;
  logic [2:0]            m1_funct3;
  logic                  m1_gnt;
  logic                  m1_rvalid;
  logic [DATA_W-1:0]     m1_rdata;
  logic                  m1_err;

  logic [DM_ADDRESS-1:0] mem_addr;
  logic                  mem_re;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_funct3,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_funct3,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output mem_addr, mem_re, mem_we, mem_be, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_funct3,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_funct3,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  mem_addr, mem_re, mem_we, mem_be, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter and access sequencer for the single data-memory port, with
// RISC-V sub-word store lane placement and load extraction/extension.
module dmem_port_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input logic                clk,
  input logic                rst_n,
  dmem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic                  pri1_q, pri1_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            f3_q, f3_d;

  logic [DM_ADDRESS-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_re_q, mem_re_d;
  logic                  mem_we_q, mem_we_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  rerr_q, rerr_d;

  logic                  gnt_any;
  logic                  sel_m1;
  logic                  s_we;
  logic [DM_ADDRESS-1:0] s_addr;
  logic [DATA_W-1:0]     s_wdata;
  logic [2:0]            s_f3;
  logic                  s_err;

  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic f3_bad;
    logic misaligned;
    f3_bad     = we ? f3[2] : ((f3 == 3'b011) || (f3[2:1] == 2'b11));
    misaligned = ((f3[1:0] == 2'b01) && off[0]) || (f3[1] && (off != 2'b00));
    return f3_bad || misaligned;
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the sub-word across lanes makes placement independent of the offset.
  function automatic logic [DATA_W-1:0] lane_data(input logic [1:0] sz, input logic [DATA_W-1:0] w);
    case (sz)
      2'b00:   return {4{w[7:0]}};
      2'b01:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] word,
                                                     input logic [1:0] off,
                                                     input logic [2:0] f3);
    logic [DATA_W-1:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  return {{(DATA_W-8){sh[7]}}, sh[7:0]};
      3'b001:  return {{(DATA_W-16){sh[15]}}, sh[15:0]};
      3'b100:  return {{(DATA_W-8){1'b0}}, sh[7:0]};
      3'b101:  return {{(DATA_W-16){1'b0}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign gnt_any = rst_n && (state_q == IDLE) && (bus.m0_req || bus.m1_req);
  assign sel_m1  = bus.m1_req && (!bus.m0_req || pri1_q);
  assign s_we    = sel_m1 ? bus.m1_we     : bus.m0_we;
  assign s_addr  = sel_m1 ? bus.m1_addr   : bus.m0_addr;
  assign s_wdata = sel_m1 ? bus.m1_wdata  : bus.m0_wdata;
  assign s_f3    = sel_m1 ? bus.m1_funct3 : bus.m0_funct3;
  assign s_err   = access_err(s_we, s_f3, s_addr[1:0]);

  always_comb begin
    state_d     = state_q;
    pri1_d      = pri1_q;
    owner_d     = owner_q;
    we_d        = we_q;
    err_d       = err_q;
    off_d       = off_q;
    f3_d        = f3_q;
    mem_addr_d  = '0;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = '0;
    mem_wdata_d = '0;
    rvalid_d    = 1'b0;
    rdata_d     = '0;
    rerr_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d = ISSUE;
          owner_d = sel_m1;
          pri1_d  = !sel_m1;
          we_d    = s_we;
          err_d   = s_err;
          off_d   = s_addr[1:0];
          f3_d    = s_f3;
          if (!s_err) begin
            mem_addr_d = {s_addr[DM_ADDRESS-1:2], 2'b00};
            if (s_we) begin
              mem_we_d    = 1'b1;
              mem_be_d    = lane_be(s_f3[1:0], s_addr[1:0]);
              mem_wdata_d = lane_data(s_f3[1:0], s_wdata);
            end else begin
              mem_re_d = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        if (we_q || err_q) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          rerr_d   = err_q;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d  = RESP;
        rvalid_d = 1'b1;
        rdata_d  = load_extract(bus.mem_rdata, off_q, f3_q);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pri1_q      <= 1'b0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pri1_q      <= pri1_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rerr_q      <= rerr_d;
    end
  end

  // Captured lane offset and funct3 are only consumed behind a state that reset clears.
  always_ff @(posedge clk) begin
    off_q <= off_d;
    f3_q  <= f3_d;
  end

  assign bus.m0_gnt    = gnt_any && !sel_m1;
  assign bus.m1_gnt    = gnt_any && sel_m1;
  assign bus.m0_rvalid = rvalid_q && !owner_q;
  assign bus.m1_rvalid = rvalid_q && owner_q;
  assign bus.m0_err    = rerr_q && !owner_q;
  assign bus.m1_err    = rerr_q && owner_q;
  assign bus.m0_rdata  = owner_q ? '0 : rdata_q;
  assign bus.m1_rdata  = owner_q ? rdata_q : '0;

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a table of single accesses with hand-computed
// results, plus sequences for round robin, dropped requests and mid-access reset.
module tb_dmem_port_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  dmem_port_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

  dmem_port_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:127];

  always @(posedge clk)
    bus.mem_rdata <= bus.mem_re ? mem[bus.mem_addr[8:2]] : 32'hDEAD_DEAD;

  typedef struct {
    logic        m;
    logic        we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] mword;
    logic [8:0]  maddr;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vt [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic m, input logic req, input vec_t v);
    if (!m) begin
      bus.m0_req = req; bus.m0_we = v.we; bus.m0_addr = v.addr;
      bus.m0_wdata = v.wdata; bus.m0_funct3 = v.f3;
    end else begin
      bus.m1_req = req; bus.m1_we = v.we; bus.m1_addr = v.addr;
      bus.m1_wdata = v.wdata; bus.m1_funct3 = v.f3;
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.m0_err, bus.m1_err,
            bus.mem_re, bus.mem_we, bus.mem_be, bus.mem_addr,
            (|bus.mem_wdata), (|bus.m0_rdata), (|bus.m1_rdata)};
  endfunction

  task automatic run_vec(input vec_t v);
    logic ld;
    ld = !v.we && !v.err;
    if (!v.we) mem[v.addr[8:2]] = v.mword;
    @(posedge clk); #1;
    drive(v.m, 1'b1, v);
    @(negedge clk);
    check("gnt", {bus.m1_gnt, bus.m0_gnt}, v.m ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    drive(v.m, 1'b0, v);
    @(negedge clk);
    check("mem_we", bus.mem_we, v.we && !v.err);
    check("mem_re", bus.mem_re, ld);
    check("mem_addr", bus.mem_addr, v.maddr);
    check("mem_be", bus.mem_be, v.be);
    check("mem_wdata", bus.mem_wdata, v.mwd);
    if (ld) begin
      @(negedge clk);
      check("early_rvalid", {bus.m1_rvalid, bus.m0_rvalid}, 2'b00);
    end
    @(negedge clk);
    check("rvalid", {bus.m1_rvalid, bus.m0_rvalid}, v.m ? 2'b10 : 2'b01);
    check("rdata", v.m ? bus.m1_rdata : bus.m0_rdata, v.rdata);
    check("err", v.m ? bus.m1_err : bus.m0_err, v.err);
    check("other_resp", v.m ? {bus.m0_err, bus.m0_rdata} : {bus.m1_err, bus.m1_rdata}, 0);
  endtask

  task automatic abort_load(input int stage);
    vec_t v;
    v = vt[8];
    @(posedge clk); #1;
    drive(1'b0, 1'b1, v);
    @(negedge clk);
    check("abort_gnt", bus.m0_gnt, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, v);
    if (stage == 2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_outs_zero", all_outs(), 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      check("abort_no_rvalid", {bus.m1_rvalid, bus.m0_rvalid}, 2'b00);
    end
  endtask

  initial begin
    vec_t    idle_v;
    logic [1:0] got;
    int      gap;

    idle_v = '{1'b0, 1'b0, 9'h0, 32'h0, 3'b000, 32'h0, 9'h0, 4'h0, 32'h0, 32'h0, 1'b0};
    //           m  we  addr     wdata          f3      mword          maddr   be    mwd            rdata          err
    vt[0]  = '{1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0,        9'h010, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 1'b0, 9'h013, 32'h0,        3'b000, 32'h80FF0000, 9'h010, 4'h0, 32'h0,        32'hFFFFFF80, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 9'h013, 32'h0,        3'b100, 32'h80FF0000, 9'h010, 4'h0, 32'h0,        32'h00000080, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 9'h006, 32'h00001234, 3'b001, 32'h0,        9'h004, 4'hC, 32'h12341234, 32'h0,        1'b0};
    vt[4]  = '{1'b0, 1'b0, 9'h005, 32'h0,        3'b010, 32'h11111111, 9'h000, 4'h0, 32'h0,        32'h0,        1'b1};
    vt[5]  = '{1'b1, 1'b0, 9'h00A, 32'h0,        3'b001, 32'h80017F00, 9'h008, 4'h0, 32'h0,        32'hFFFF8001, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 9'h00A, 32'h0,        3'b101, 32'h80017F00, 9'h008, 4'h0, 32'h0,        32'h00008001, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 9'h021, 32'h000000A5, 3'b000, 32'h0,        9'h020, 4'h2, 32'hA5A5A5A5, 32'h0,        1'b0};
    vt[8]  = '{1'b0, 1'b0, 9'h024, 32'h0,        3'b010, 32'h12345678, 9'h024, 4'h0, 32'h0,        32'h12345678, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 9'h003, 32'h00001234, 3'b001, 32'h0,        9'h000, 4'h0, 32'h0,        32'h0,        1'b1};
    vt[10] = '{1'b0, 1'b0, 9'h000, 32'h0,        3'b011, 32'h22222222, 9'h000, 4'h0, 32'h0,        32'h0,        1'b1};
    vt[11] = '{1'b1, 1'b1, 9'h000, 32'h000000FF, 3'b100, 32'h0,        9'h000, 4'h0, 32'h0,        32'h0,        1'b1};
    vt[12] = '{1'b1, 1'b0, 9'h1FF, 32'h0,        3'b100, 32'hAB000000, 9'h1FC, 4'h0, 32'h0,        32'h000000AB, 1'b0};
    vt[13] = '{1'b0, 1'b0, 9'h002, 32'h0,        3'b000, 32'h007F0000, 9'h000, 4'h0, 32'h0,        32'h0000007F, 1'b0};
    vt[14] = '{1'b1, 1'b1, 9'h102, 32'hFFFFBEEF, 3'b001, 32'h0,        9'h100, 4'hC, 32'hBEEFBEEF, 32'h0,        1'b0};
    vt[15] = '{1'b0, 1'b1, 9'h002, 32'h01020304, 3'b010, 32'h0,        9'h000, 4'h0, 32'h0,        32'h0,        1'b1};

    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    drive(1'b0, 1'b0, idle_v);
    drive(1'b1, 1'b0, idle_v);
    rst_n = 1'b0;
    #1;
    check("reset_outs", all_outs(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_outs", all_outs(), 0);

    foreach (vt[i]) run_vec(vt[i]);

    // Both requesters held high after a fresh reset: grants alternate starting with m0.
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b1, vt[0]);
    drive(1'b1, 1'b1, vt[3]);
    for (int k = 0; k < 4; k++) begin
      got = 2'b00;
      gap = 0;
      for (int c = 0; c < 6 && got == 2'b00; c++) begin
        @(negedge clk);
        got = {bus.m1_gnt, bus.m0_gnt};
        gap = c;
      end
      check("rr_gnt", got, k[0] ? 2'b10 : 2'b01);
      if (k > 0) check("rr_gap", gap, 2);
      @(posedge clk);
    end
    #1;
    drive(1'b0, 1'b0, idle_v);
    drive(1'b1, 1'b0, idle_v);
    repeat (3) @(posedge clk);

    // m1 raises then withdraws its request while m0's store is in flight.
    #1;
    drive(1'b0, 1'b1, vt[0]);
    @(negedge clk);
    check("drop_m0_gnt", bus.m0_gnt, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, idle_v);
    drive(1'b1, 1'b1, vt[3]);
    @(negedge clk);
    check("drop_busy_gnt", {bus.m1_gnt, bus.m0_gnt}, 2'b00);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, idle_v);
    @(negedge clk);
    check("drop_m0_rvalid", {bus.m1_rvalid, bus.m0_rvalid}, 2'b01);
    @(negedge clk);
    check("drop_idle_gnt", {bus.m1_gnt, bus.m0_gnt}, 2'b00);
    @(negedge clk);
    check("drop_no_issue", {bus.mem_re, bus.mem_we}, 2'b00);

    abort_load(1);
    run_vec(vt[6]);
    abort_load(2);
    run_vec(vt[8]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
